core_run_ctrl: RTL and testbench
================================

// Module: core_run_ctrl
// PURPOSE
//  Synthesizable run controller that generalises the clk/rst/"run N cycles then stop" TB pattern.
//  Sequences per-core reset release, gates core clock-enables for a cycle budget, and supports
//  free-run, single-step, stop and restart.
//  Sits between the top-level clk/rst and up to NUM_CORES ARM pipeline instances.
//  Drives each core's active-high rst and clock-enable.
// PARAMETERS
//  NUM_CORES        1   number of controlled cores (width of mask/rst/en vectors)
//  CNT_W            32  width of cycle counter and budget
//  RST_HOLD_CYCLES  1   cycles core_rst stays high after start; must be >= 1
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-low reset
//  start      in   1          start/restart pulse; honoured only in IDLE or HALT
//  budget     in   CNT_W      enabled-cycle budget; latched on accepted start
//  core_mask  in   NUM_CORES  cores to run; latched on accepted start
//  step_mode  in   1          1 = single-step (PAUSE), 0 = free-run (RUN)
//  step_req   in   1          in PAUSE: request exactly one enabled cycle
//  stop_req   in   1          force HALT from HOLD/RUN/PAUSE/STEP
//  core_rst   out  NUM_CORES  per-core active-high reset
//  core_en    out  NUM_CORES  per-core clock enable
//  cycle_cnt  out  CNT_W      enabled cycles elapsed since last start
//  running    out  1          1 while in RUN or STEP
//  halted     out  1          1 in HALT
//  budget_hit out  1          1 in HALT when the budget caused the stop
// BEHAVIOUR
//  - All outputs registered.
//  - rst low, asynchronously:
//      state=IDLE, core_rst='1, core_en=0, cycle_cnt=0, running=0, halted=0, budget_hit=0.
//    Applies immediately mid-operation; nothing resumes without a new start.
//  - FSM states: IDLE, HOLD, RUN, PAUSE, STEP, HALT.
//  - IDLE:
//      core_rst='1, core_en=0.
//      start -> HOLD: latch budget/core_mask, clear cycle_cnt and budget_hit, hold_cnt=0.
//  - HOLD:
//      core_rst='1.
//      hold_cnt counts; after RST_HOLD_CYCLES cycles in HOLD -> PAUSE if step_mode, else RUN.
//      If latched budget==0 -> HALT with budget_hit=1 instead.
//  - RUN/PAUSE/STEP/HALT:
//      core_rst = ~mask_lat; masked-out cores stay in reset.
//  - RUN:
//      core_en=mask_lat; cycle_cnt+1 on every RUN edge.
//      When cycle_cnt+1 == budget_lat -> HALT, budget_hit=1.
//      Else step_mode=1 -> PAUSE.
//  - PAUSE:
//      core_en=0.
//      step_req -> STEP; step_mode=0 -> RUN.
//  - STEP:
//      core_en=mask_lat for exactly one cycle; cycle_cnt+1.
//      -> HALT with budget_hit=1 if budget reached, else PAUSE.
//      step_req during STEP is ignored (no queueing).
//  - HALT:
//      core_en=0, core_rst unchanged (core state preserved for inspection).
//      halted=1. start -> HOLD (restart).
//  - Priority when events coincide: rst > stop_req > budget reached > step_mode change > step_req.
//    stop_req in RUN/STEP: that cycle is still enabled and counted; budget_hit=0.
//  - start is ignored outside IDLE/HALT.
//    budget/core_mask changes are ignored after latching.
//  - cycle_cnt never exceeds budget_lat (no wrap); max budget = 2^CNT_W-1.
//  - Latency: start at edge k.
//      core_rst high through edge k+RST_HOLD_CYCLES.
//      First core_en cycle follows that edge.
//    Total enabled cycles in free-run = budget_lat exactly.
// TESTING
//  1. Free-run (defaults): rst low 2 cycles, start, budget=20, mask=1
//     -> core_rst high 1 cycle, core_en high exactly 20 consecutive cycles,
//        then halted=1, budget_hit=1, cycle_cnt=20.
//  2. Stop: budget=20; stop_req high in the cycle where cycle_cnt==7
//     -> cycle_cnt=8, halted=1, budget_hit=0, core_en=0 next cycle.
//  3. Step: step_mode=1, budget=5, 3 step_req pulses (one with step_req held 2 cycles)
//     -> exactly 3 single-cycle core_en pulses, cycle_cnt=3, state PAUSE.
//        2 more pulses -> HALT, budget_hit=1.
//  4. Zero budget: budget=0, start
//     -> core_en never asserts; halted=1, budget_hit=1 after hold.
//  5. Async reset mid-run at cycle_cnt=10, rst low between edges
//     -> core_rst='1, core_en=0, cycle_cnt=0, halted=0 immediately.
//        No run after rst release until start.
//  6. NUM_CORES=4, mask=4'b0101, budget=3
//     -> in RUN: core_rst=4'b1010, core_en=4'b0101.
//        start from HALT clears cycle_cnt/budget_hit and re-pulses core_rst=4'b1111.

Source files
------------

// File: rtl/core_run_ctrl.sv
// core_run_ctrl
// Run controller for up to NUM_CORES pipeline instances. After an accepted
// start it holds the selected cores in reset for RST_HOLD_CYCLES edges, then
// gives them clock enables until an enabled-cycle budget is used up. It can
// also single-step, stop and restart them. Cores left out of the mask stay in
// reset. Every output comes straight from a flop.
//
// Parameters:
//   NUM_CORES       width of the mask / reset / enable vectors
//   CNT_W           width of the budget and of the enabled-cycle counter
//   RST_HOLD_CYCLES edges core_rst stays high after start (must be >= 1)

module core_run_ctrl #(
    parameter int NUM_CORES       = 1,
    parameter int CNT_W           = 32,
    parameter int RST_HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     budget,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic                 step_mode,
    input  logic                 step_req,
    input  logic                 stop_req,
    output logic [NUM_CORES-1:0] core_rst,
    output logic [NUM_CORES-1:0] core_en,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic                 running,
    output logic                 halted,
    output logic                 budget_hit
);

    // The hold counter runs from 0 to RST_HOLD_CYCLES-1. It is at least 1 bit wide.
    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_PAUSE,
        S_STEP,
        S_HALT
    } state_t;

    state_t               state;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [CNT_W-1:0]     budget_lat;
    logic [NUM_CORES-1:0] mask_lat;
    logic [CNT_W-1:0]     cnt_next;
    logic                 budget_done;
    logic                 accept;

    // Saturating increment. The counter stops at all-ones and never wraps.
    // In normal use it stops earlier, at budget_lat.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign cnt_next    = cnt_inc(cycle_cnt);
    assign budget_done = (cnt_next == budget_lat);
    assign accept      = start && ((state == S_IDLE) || (state == S_HALT));

    // Capture budget and mask on an accepted start. These are data registers
    // and have no reset, because nothing reads them before the first start.
    always_ff @(posedge clk) begin
        if (accept) begin
            budget_lat <= budget;
            mask_lat   <= core_mask;
        end
    end

    // Run-control FSM. Each output is registered from the state being entered,
    // so it is valid for the whole cycle that state lasts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            cycle_cnt  <= '0;
            core_rst   <= '1;
            core_en    <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
            budget_hit <= 1'b0;
        end else begin
            case (state)
                // IDLE and HALT both wait for start.
                // In HALT the reset and enable outputs stay frozen so the
                // core state can be inspected.
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state      <= S_HOLD;
                        hold_cnt   <= '0;
                        cycle_cnt  <= '0;
                        core_rst   <= '1;
                        core_en    <= '0;
                        running    <= 1'b0;
                        halted     <= 1'b0;
                        budget_hit <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (stop_req) begin
                        state      <= S_HALT;
                        core_rst   <= ~mask_lat;
                        core_en    <= '0;
                        running    <= 1'b0;
                        halted     <= 1'b1;
                        budget_hit <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        core_rst <= ~mask_lat;
                        if (budget_lat == '0) begin
                            // A zero budget allows no enabled cycles.
                            state      <= S_HALT;
                            core_en    <= '0;
                            running    <= 1'b0;
                            halted     <= 1'b1;
                            budget_hit <= 1'b1;
                        end else if (step_mode) begin
                            state   <= S_PAUSE;
                            core_en <= '0;
                            running <= 1'b0;
                        end else begin
                            state   <= S_RUN;
                            core_en <= mask_lat;
                            running <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                // A cycle spent in RUN is an enabled cycle, so it is always
                // counted, even when stop_req arrives in that same cycle.
                S_RUN: begin
                    cycle_cnt <= cnt_next;
                    if (stop_req) begin
                        state      <= S_HALT;
                        core_en    <= '0;
                        running    <= 1'b0;
                        halted     <= 1'b1;
                        budget_hit <= 1'b0;
                    end else if (budget_done) begin
                        state      <= S_HALT;
                        core_en    <= '0;
                        running    <= 1'b0;
                        halted     <= 1'b1;
                        budget_hit <= 1'b1;
                    end else if (step_mode) begin
                        state   <= S_PAUSE;
                        core_en <= '0;
                        running <= 1'b0;
                    end
                end

                S_PAUSE: begin
                    if (stop_req) begin
                        state      <= S_HALT;
                        core_en    <= '0;
                        running    <= 1'b0;
                        halted     <= 1'b1;
                        budget_hit <= 1'b0;
                    end else if (!step_mode) begin
                        state   <= S_RUN;
                        core_en <= mask_lat;
                        running <= 1'b1;
                    end else if (step_req) begin
                        state   <= S_STEP;
                        core_en <= mask_lat;
                        running <= 1'b1;
                    end
                end

                // STEP is one enabled cycle. step_req is not looked at here,
                // so holding it high does not queue a second step.
                S_STEP: begin
                    cycle_cnt <= cnt_next;
                    core_en   <= '0;
                    running   <= 1'b0;
                    if (stop_req) begin
                        state      <= S_HALT;
                        halted     <= 1'b1;
                        budget_hit <= 1'b0;
                    end else if (budget_done) begin
                        state      <= S_HALT;
                        halted     <= 1'b1;
                        budget_hit <= 1'b1;
                    end else begin
                        state <= S_PAUSE;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    core_rst <= '1;
                    core_en  <= '0;
                    running  <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl
// Directed bench for core_run_ctrl with NUM_CORES=4 and RST_HOLD_CYCLES=1.
// A table of per-cycle vectors covers stepping, zero budget, masking,
// restart and stop priority. Hand-written sequences cover free-run length,
// stop at a given count, and asynchronous reset in the middle of a run.

module tb_core_run_ctrl;

    localparam int NC = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] budget;
    logic [NC-1:0] core_mask;
    logic          step_mode;
    logic          step_req;
    logic          stop_req;
    logic [NC-1:0] core_rst;
    logic [NC-1:0] core_en;
    logic [CW-1:0] cycle_cnt;
    logic          running;
    logic          halted;
    logic          budget_hit;

    int total = 0;
    int bad   = 0;

    core_run_ctrl #(
        .NUM_CORES      (NC),
        .CNT_W          (CW),
        .RST_HOLD_CYCLES(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .budget    (budget),
        .core_mask (core_mask),
        .step_mode (step_mode),
        .step_req  (step_req),
        .stop_req  (stop_req),
        .core_rst  (core_rst),
        .core_en   (core_en),
        .cycle_cnt (cycle_cnt),
        .running   (running),
        .halted    (halted),
        .budget_hit(budget_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [CW-1:0] budget;
        logic [NC-1:0] mask;
        logic          step_mode;
        logic          step_req;
        logic          stop_req;
        logic [NC-1:0] e_rst;
        logic [NC-1:0] e_en;
        logic [CW-1:0] e_cnt;
        logic          e_run;
        logic          e_halt;
        logic          e_bh;
    } vec_t;

    localparam int NV = 40;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic st, input int bud, input logic [NC-1:0] m,
                                input logic sm, input logic sr, input logic sp,
                                input logic [NC-1:0] er, input logic [NC-1:0] ee,
                                input int ec, input logic eru, input logic eh,
                                input logic eb);
        vec_t v;
        v.start = st; v.budget = bud; v.mask = m;
        v.step_mode = sm; v.step_req = sr; v.stop_req = sp;
        v.e_rst = er; v.e_en = ee; v.e_cnt = ec;
        v.e_run = eru; v.e_halt = eh; v.e_bh = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Wait for a rising edge, then step 1 time unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string p, input logic [NC-1:0] er, input logic [NC-1:0] ee,
                           input int ec, input logic eru, input logic eh, input logic eb);
        chk({p, "_rst"},  core_rst,  er);
        chk({p, "_en"},   core_en,   ee);
        chk({p, "_cnt"},  cycle_cnt, ec);
        chk({p, "_run"},  running,   eru);
        chk({p, "_halt"}, halted,    eh);
        chk({p, "_bh"},   budget_hit, eb);
    endtask

    initial begin
        int n;
        int guard;

        // Row fields: inputs {start, budget, mask, step_mode, step_req, stop_req}
        // and expected outputs after the next edge {rst, en, cnt, run, halt, bh}.
        // Single-step: 3 steps (the second with step_req held 2 cycles), then 2 more to budget 5
        tbl[0]  = mk(1, 5, 4'b0001, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 5, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 0, 0, 0, 0);
        tbl[2]  = mk(0, 5, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 0, 0, 0, 0);
        tbl[3]  = mk(0, 5, 4'b0001, 1, 1, 0, 4'b1110, 4'b0001, 0, 1, 0, 0);
        tbl[4]  = mk(0, 5, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 1, 0, 0, 0);
        tbl[5]  = mk(0, 5, 4'b0001, 1, 1, 0, 4'b1110, 4'b0001, 1, 1, 0, 0);
        tbl[6]  = mk(0, 5, 4'b0001, 1, 1, 0, 4'b1110, 4'b0000, 2, 0, 0, 0);
        tbl[7]  = mk(0, 5, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 2, 0, 0, 0);
        tbl[8]  = mk(0, 5, 4'b0001, 1, 1, 0, 4'b1110, 4'b0001, 2, 1, 0, 0);
        tbl[9]  = mk(0, 5, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 3, 0, 0, 0);
        tbl[10] = mk(0, 5, 4'b0001, 1, 1, 0, 4'b1110, 4'b0001, 3, 1, 0, 0);
        tbl[11] = mk(0, 5, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 4, 0, 0, 0);
        tbl[12] = mk(0, 5, 4'b0001, 1, 1, 0, 4'b1110, 4'b0001, 4, 1, 0, 0);
        tbl[13] = mk(0, 5, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 5, 0, 1, 1);
        tbl[14] = mk(0, 5, 4'b0001, 1, 1, 0, 4'b1110, 4'b0000, 5, 0, 1, 1);
        // Zero budget: halt with budget_hit straight after the hold cycle
        tbl[15] = mk(1, 0, 4'b0001, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 4'b0001, 0, 0, 0, 4'b1110, 4'b0000, 0, 0, 1, 1);
        tbl[17] = mk(0, 0, 4'b0001, 0, 0, 0, 4'b1110, 4'b0000, 0, 0, 1, 1);
        // Mask 0101, budget 3
        tbl[18] = mk(1, 3, 4'b0101, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
        tbl[19] = mk(0, 3, 4'b0101, 0, 0, 0, 4'b1010, 4'b0101, 0, 1, 0, 0);
        tbl[20] = mk(0, 3, 4'b0101, 0, 0, 0, 4'b1010, 4'b0101, 1, 1, 0, 0);
        tbl[21] = mk(0, 3, 4'b0101, 0, 0, 0, 4'b1010, 4'b0101, 2, 1, 0, 0);
        tbl[22] = mk(0, 3, 4'b0101, 0, 0, 0, 4'b1010, 4'b0000, 3, 0, 1, 1);
        // Restart from HALT; budget/mask changes and start during RUN are ignored
        tbl[23] = mk(1, 2, 4'b0101, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
        tbl[24] = mk(0, 7, 4'b0011, 0, 0, 0, 4'b1010, 4'b0101, 0, 1, 0, 0);
        tbl[25] = mk(1, 7, 4'b0011, 0, 0, 0, 4'b1010, 4'b0101, 1, 1, 0, 0);
        tbl[26] = mk(0, 7, 4'b0011, 0, 0, 0, 4'b1010, 4'b0000, 2, 0, 1, 1);
        // step_mode switching PAUSE->RUN->PAUSE, then stop from PAUSE
        tbl[27] = mk(1, 10, 4'b0001, 1, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
        tbl[28] = mk(0, 10, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 0, 0, 0, 0);
        tbl[29] = mk(0, 10, 4'b0001, 0, 0, 0, 4'b1110, 4'b0001, 0, 1, 0, 0);
        tbl[30] = mk(0, 10, 4'b0001, 0, 0, 0, 4'b1110, 4'b0001, 1, 1, 0, 0);
        tbl[31] = mk(0, 10, 4'b0001, 1, 0, 0, 4'b1110, 4'b0000, 2, 0, 0, 0);
        tbl[32] = mk(0, 10, 4'b0001, 1, 0, 1, 4'b1110, 4'b0000, 2, 0, 1, 0);
        // stop during HOLD
        tbl[33] = mk(1, 10, 4'b0001, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
        tbl[34] = mk(0, 10, 4'b0001, 0, 0, 1, 4'b1110, 4'b0000, 0, 0, 1, 0);
        tbl[35] = mk(0, 10, 4'b0001, 0, 0, 0, 4'b1110, 4'b0000, 0, 0, 1, 0);
        // stop_req coinciding with the budget: stop wins, budget_hit=0
        tbl[36] = mk(1, 2, 4'b0001, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, 0);
        tbl[37] = mk(0, 2, 4'b0001, 0, 0, 0, 4'b1110, 4'b0001, 0, 1, 0, 0);
        tbl[38] = mk(0, 2, 4'b0001, 0, 0, 0, 4'b1110, 4'b0001, 1, 1, 0, 0);
        tbl[39] = mk(0, 2, 4'b0001, 0, 0, 1, 4'b1110, 4'b0000, 2, 0, 1, 0);

        rst = 1'b0; start = 1'b0; budget = '0; core_mask = '0;
        step_mode = 1'b0; step_req = 1'b0; stop_req = 1'b0;
        tick();
        tick();
        chk_all("reset", 4'b1111, 4'b0000, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        chk_all("idle", 4'b1111, 4'b0000, 0, 0, 0, 0);

        // Free-run, budget 20
        budget = 20; core_mask = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t1_hold", 4'b1111, 4'b0000, 0, 0, 0, 0);
        tick();
        chk_all("t1_run0", 4'b1110, 4'b0001, 0, 1, 0, 0);
        n = 0;
        guard = 0;
        while (core_en == 4'b0001 && guard < 60) begin
            n++;
            guard++;
            tick();
        end
        chk("t1_en_cycles", n, 20);
        chk_all("t1_end", 4'b1110, 4'b0000, 20, 0, 1, 1);
        tick();
        chk("t1_cnt_hold", cycle_cnt, 20);

        // Stop at cycle_cnt==7
        budget = 20; start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("t2_hold", 4'b1111, 4'b0000, 0, 0, 0, 0);
        guard = 0;
        while (cycle_cnt != 7 && guard < 40) begin
            guard++;
            tick();
        end
        chk("t2_reach7", cycle_cnt, 7);
        chk("t2_en7", core_en, 4'b0001);
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        chk_all("t2_stop", 4'b1110, 4'b0000, 8, 0, 1, 0);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            start     = tbl[i].start;
            budget    = tbl[i].budget;
            core_mask = tbl[i].mask;
            step_mode = tbl[i].step_mode;
            step_req  = tbl[i].step_req;
            stop_req  = tbl[i].stop_req;
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].e_rst, tbl[i].e_en, tbl[i].e_cnt,
                    tbl[i].e_run, tbl[i].e_halt, tbl[i].e_bh);
        end
        start = 1'b0; step_mode = 1'b0; step_req = 1'b0; stop_req = 1'b0;

        // Async reset in the middle of a run at cycle_cnt==10
        budget = 20; core_mask = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (cycle_cnt != 10 && guard < 40) begin
            guard++;
            tick();
        end
        chk("t5_reach10", cycle_cnt, 10);
        #2;
        rst = 1'b0;
        #1;
        chk_all("t5_async", 4'b1111, 4'b0000, 0, 0, 0, 0);
        tick();
        chk_all("t5_held", 4'b1111, 4'b0000, 0, 0, 0, 0);
        #3;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_all($sformatf("t5_norun%0d", k), 4'b1111, 4'b0000, 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
